mac_divider: RTL and testbench

//   Inverse of the a*b+c MAC pipeline. Takes a 16-bit MAC result and the
//   8-bit multiplier operand b, and recovers quotient = y / b and

---
 rtl/mac_divider.sv | 129 ++++++++++++
 tb/tb_mac_divider.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mac_divider.sv
// Restoring divider that recovers y / b and y % b from a MAC result y = a*b + c.
// One quotient bit per clock; start/busy/done handshake with held results.
`timescale 1ns/1ps
module mac_divider #(
    parameter int DW = 16,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] data_in,
    input  logic [BW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [BW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    // S_ZERO is the single non-busy cycle a divide-by-zero spends before DONE.
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ZERO, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_dividend;
    logic [DW-1:0] r_quo_acc;
    logic [BW-1:0] r_div;
    logic [BW-1:0] r_partial;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_quotient;
    logic [BW-1:0] r_remainder;
    logic          r_dbz;

    logic [BW:0]   w_trial;
    logic          w_ge;
    logic [BW-1:0] w_diff;
    logic [BW-1:0] w_part_nxt;
    logic [DW-1:0] w_quo_nxt;
    logic          w_last;

    // The stored partial remainder is always below the divisor, so only the
    // shifted trial value needs the extra bit.
    assign w_trial    = {r_partial, r_dividend[DW-1]};
    assign w_ge       = (w_trial >= {1'b0, r_div});
    assign w_diff     = w_trial[BW-1:0] - r_div;
    assign w_part_nxt = w_ge ? w_diff : w_trial[BW-1:0];
    assign w_quo_nxt  = {r_quo_acc[DW-2:0], w_ge};
    assign w_last     = (r_count == CW'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (divisor == '0) ? S_ZERO : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_ZERO:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dividend  <= '0;
            r_quo_acc   <= '0;
            r_div       <= '0;
            r_partial   <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dividend  <= data_in;
                        r_div       <= divisor;
                        r_partial   <= '0;
                        r_quo_acc   <= '0;
                        r_count     <= CW'(DW);
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_dbz       <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_dividend <= {r_dividend[DW-2:0], 1'b0};
                    r_partial  <= w_part_nxt;
                    r_quo_acc  <= w_quo_nxt;
                    r_count    <= r_count - CW'(1);
                    if (w_last) begin
                        r_quotient  <= w_quo_nxt;
                        r_remainder <= w_part_nxt;
                    end
                end
                S_ZERO: begin
                    r_quotient  <= '1;
                    r_remainder <= '0;
                    r_dbz       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_BUSY);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mac_divider.sv
// Directed bench for mac_divider: a scoreboard of expected results is filled
// as requests are accepted and drained whenever done pulses.
`timescale 1ns/1ps
module tb_mac_divider;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] data_in;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mac_divider #(.DW(16), .BW(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .data_in(data_in),
        .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] y, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 16'hFFFF; e.r = 8'd0; e.dz = 1'b1;
        end else begin
            e.q = y / {8'd0, b}; e.r = 8'(y % {8'd0, b}); e.dz = 1'b0;
        end
        return e;
    endfunction

    // Every done pulse must have a pending expectation and match it.
    always @(negedge clk) begin
        if (reset_n && done) begin
            chk("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dz));
            end
        end
    end

    task automatic do_div(input string tag, input logic [15:0] y, input logic [7:0] b);
        int   lat;
        int   busy_n;
        bit   seen;
        exp_t e;
        e = model(y, b);
        @(negedge clk);
        start = 1'b1; data_in = y; divisor = b;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; data_in = 16'($urandom); divisor = 8'($urandom);
        chk({tag, "_clr_q"}, 32'(quotient), 32'd0);
        chk({tag, "_clr_dz"}, 32'(div_by_zero), 32'd0);
        busy_n = busy ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
        end
        chk({tag, "_latency"}, 32'(lat), (b == 8'd0) ? 32'd1 : 32'd16);
        chk({tag, "_busy_cycles"}, 32'(busy_n), (b == 8'd0) ? 32'd0 : 32'd16);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_held_q"}, 32'(quotient), 32'(e.q));
        chk({tag, "_held_r"}, 32'(remainder), 32'(e.r));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] y;
        logic [7:0]  b;
        reset_n = 1'b0; start = 1'b0; data_in = '0; divisor = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        do_div("t1", 16'd257, 8'd10);
        do_div("t2", 16'd65279, 8'd255);
        do_div("t3a", 16'hFFFF, 8'd1);
        do_div("t3b", 16'd5, 8'd200);
        do_div("t4z", 16'd1234, 8'd0);
        chk("t4_dz_held", 32'(div_by_zero), 32'd1);
        do_div("t4b", 16'd1000, 8'd9);

        // start held high: accepts land every 18 edges (16 busy, 1 done, 1 idle)
        @(negedge clk);
        y = 16'($urandom); b = 8'($urandom_range(1, 255));
        start = 1'b1; data_in = y; divisor = b;
        sb.push_back(model(y, b));
        for (int c = 0; c < 54; c++) begin
            @(posedge clk); #1;
            chk("t5_done_slot", 32'(done), 32'((c % 18) == 16));
            @(negedge clk);
            y = 16'($urandom); b = 8'($urandom_range(1, 255));
            data_in = y; divisor = b;
            if (((c + 1) % 18) == 0 && (c + 1) < 54) sb.push_back(model(y, b));
        end
        start = 1'b0;
        repeat (2) @(posedge clk);

        // abort mid-division
        @(negedge clk);
        start = 1'b1; data_in = 16'd1000; divisor = 8'd3;
        sb.push_back(model(16'd1000, 8'd3));
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("t6_pre_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_q", 32'(quotient), 32'd0);
        chk("t6_r", 32'(remainder), 32'd0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_idle_busy", 32'(busy), 32'd0);
        do_div("t6b", 16'd100, 8'd7);
        chk("t6b_q", 32'(quotient), 32'd14);
        chk("t6b_r", 32'(remainder), 32'd2);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
